// File: rtl/motion_seq_if.sv
// Request/accept channels from the manual and auto command sources into the motion sequencer.
interface motion_seq_if #(
    parameter int DUR_W = 8
);
    logic             m_valid;
    logic [2:0]       m_cmd;
    logic [DUR_W-1:0] m_dur;
    logic             m_ready;
    logic             a_valid;
    logic [2:0]       a_cmd;
    logic [DUR_W-1:0] a_dur;
    logic             a_ready;

    modport master (
        output m_valid, m_cmd, m_dur, a_valid, a_cmd, a_dur,
        input  m_ready, a_ready
    );

    modport slave (
        input  m_valid, m_cmd, m_dur, a_valid, a_cmd, a_dur,
        output m_ready, a_ready
    );
endinterface

// File: rtl/motion_sequencer.sv
// Arbitrated, timed H-bridge direction sequencer with brake dead-time and estop.
// state | meaning: IDLE brake, accepting | DEAD brake before direction change | RUN drive pins for dur ticks
module motion_sequencer #(
    parameter int TICK_CYCLES     = 5_000_000,
    parameter int DEADTIME_CYCLES = 2_500_000,
    parameter int DUR_W           = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_estop,
    motion_seq_if.slave  bus,
    output logic         o_ina1,
    output logic         o_inb1,
    output logic         o_ina2,
    output logic         o_inb2,
    output logic         o_busy,
    output logic         o_active_src,
    output logic         o_done,
    output logic         o_err
);
    localparam int CNT_MAX = (TICK_CYCLES > DEADTIME_CYCLES) ? TICK_CYCLES : DEADTIME_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [2:0] CMD_STOP = 3'd0;
    localparam logic [2:0] CMD_LAST = 3'd4;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DEAD = 2'd1, S_RUN = 2'd2} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cyc;
    logic [DUR_W-1:0] r_tick, r_dur;
    logic [2:0]       r_cmd, r_last;
    logic             r_src, r_done, r_err;
    logic [3:0]       r_pins;

    logic             w_tick_end, w_run_end, w_dead_end;
    logic             w_m_ready, w_a_ready, w_acc, w_acc_src, w_acc_bad, w_acc_zero, w_need_dead;
    logic [2:0]       w_acc_cmd;
    logic [DUR_W-1:0] w_acc_dur;
    logic [3:0]       w_pins_nxt;
    logic             w_done_nxt, w_err_nxt;

    function automatic logic [3:0] pin_map(input logic [2:0] cmd);
        case (cmd)
            3'd1:    pin_map = 4'b0101;
            3'd2:    pin_map = 4'b1010;
            3'd3:    pin_map = 4'b0110;
            3'd4:    pin_map = 4'b1001;
            default: pin_map = 4'b0000;
        endcase
    endfunction

    assign w_tick_end = (r_cyc == CNT_W'(TICK_CYCLES - 1));
    assign w_run_end  = (r_state == S_RUN) && w_tick_end && (r_tick == r_dur - DUR_W'(1));
    assign w_dead_end = (r_state == S_DEAD) && (r_cyc == CNT_W'(DEADTIME_CYCLES - 1));

    // Manual may preempt an auto job, except on its final cycle where completion wins.
    assign w_m_ready = !i_rst && !i_estop && bus.m_valid &&
                       ((r_state == S_IDLE) || (r_src && !w_run_end));
    assign w_a_ready = !i_rst && !i_estop && bus.a_valid && !bus.m_valid && (r_state == S_IDLE);
    assign bus.m_ready = w_m_ready;
    assign bus.a_ready = w_a_ready;

    assign w_acc       = w_m_ready || w_a_ready;
    assign w_acc_src   = !w_m_ready;
    assign w_acc_cmd   = w_m_ready ? bus.m_cmd : bus.a_cmd;
    assign w_acc_dur   = w_m_ready ? bus.m_dur : bus.a_dur;
    assign w_acc_bad   = (w_acc_cmd > CMD_LAST);
    assign w_acc_zero  = (w_acc_dur == '0);
    assign w_need_dead = (w_acc_cmd != CMD_STOP) && (r_last != CMD_STOP) && (w_acc_cmd != r_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_estop) begin
            w_state_nxt = S_IDLE;
        end else if (w_acc) begin
            if (w_acc_bad || w_acc_zero) w_state_nxt = S_IDLE;
            else if (w_need_dead)        w_state_nxt = S_DEAD;
            else                         w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_DEAD:  if (w_dead_end) w_state_nxt = S_RUN;
                S_RUN:   if (w_run_end)  w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_pins_nxt = 4'b0000;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        if (!i_estop) begin
            w_err_nxt  = w_acc && w_acc_bad;
            w_done_nxt = w_run_end || (w_acc && !w_acc_bad && w_acc_zero);
        end
        if (w_state_nxt == S_RUN) w_pins_nxt = pin_map(w_acc ? w_acc_cmd : r_cmd);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc  <= '0;
            r_tick <= '0;
            r_dur  <= '0;
            r_cmd  <= CMD_STOP;
            r_last <= CMD_STOP;
            r_src  <= 1'b0;
            r_pins <= 4'b0000;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_pins <= w_pins_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if (i_estop) begin
                r_cyc  <= '0;
                r_tick <= '0;
                r_last <= CMD_STOP;
            end else if (w_acc) begin
                r_cyc  <= '0;
                r_tick <= '0;
                r_src  <= w_acc_src;
                r_cmd  <= w_acc_cmd;
                r_dur  <= w_acc_dur;
                if (w_state_nxt == S_RUN) r_last <= w_acc_cmd;
            end else if (r_state == S_DEAD) begin
                if (w_dead_end) begin
                    r_cyc  <= '0;
                    r_last <= r_cmd;
                end else begin
                    r_cyc <= r_cyc + CNT_W'(1);
                end
            end else if (r_state == S_RUN) begin
                if (w_run_end) begin
                    r_cyc  <= '0;
                    r_tick <= '0;
                end else if (w_tick_end) begin
                    r_cyc  <= '0;
                    r_tick <= r_tick + DUR_W'(1);
                end else begin
                    r_cyc <= r_cyc + CNT_W'(1);
                end
            end
        end
    end

    assign {o_ina1, o_inb1, o_ina2, o_inb2} = r_pins;
    assign o_busy       = (r_state != S_IDLE);
    assign o_active_src = r_src;
    assign o_done       = r_done;
    assign o_err        = r_err;
endmodule

// File: tb/tb_motion_sequencer.sv
// Directed scenarios plus random traffic, every cycle compared against a remaining-cycles job model.
module tb_motion_sequencer;
    localparam int TICK  = 4;
    localparam int DEADC = 3;
    localparam int DW    = 8;

    logic clk = 1'b0;
    logic rst, estop;
    logic ina1, inb1, ina2, inb2, busy, active_src, done, err;

    always #5 clk = ~clk;

    motion_seq_if #(.DUR_W(DW)) bus ();

    motion_sequencer #(
        .TICK_CYCLES(TICK), .DEADTIME_CYCLES(DEADC), .DUR_W(DW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_estop(estop), .bus(bus),
        .o_ina1(ina1), .o_inb1(inb1), .o_ina2(ina2), .o_inb2(inb2),
        .o_busy(busy), .o_active_src(active_src), .o_done(done), .o_err(err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference job model: remaining brake and drive cycles of the current job.
    int         brake_left = 0;
    int         run_left   = 0;
    logic [2:0] job_cmd    = 3'd0;
    logic [2:0] last_dir   = 3'd0;
    logic       job_src    = 1'b0;
    logic [3:0] e_pins     = 4'b0000;
    logic       e_done     = 1'b0;
    logic       e_err      = 1'b0;
    logic       e_mr       = 1'b0;
    logic       e_ar       = 1'b0;
    logic [3:0] pmap [0:4] = '{4'b0000, 4'b0101, 4'b1010, 4'b0110, 4'b1001};

    task automatic step();
        logic          idle, finishing;
        logic [2:0]    c;
        logic [DW-1:0] d;
        @(negedge clk);
        idle      = (brake_left == 0) && (run_left == 0);
        finishing = (brake_left == 0) && (run_left == 1);
        e_mr = !rst && !estop && bus.m_valid && (idle || (job_src && !finishing));
        e_ar = !rst && !estop && bus.a_valid && !bus.m_valid && idle;
        chk("m_ready", 32'(bus.m_ready), 32'(e_mr));
        chk("a_ready", 32'(bus.a_ready), 32'(e_ar));
        chk("pins", 32'({ina1, inb1, ina2, inb2}), 32'(e_pins));
        chk("busy", 32'(busy), 32'(!idle));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("active_src", 32'(active_src), 32'(job_src));
        e_done = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            brake_left = 0; run_left = 0; last_dir = 3'd0; job_src = 1'b0; job_cmd = 3'd0;
        end else if (estop) begin
            brake_left = 0; run_left = 0; last_dir = 3'd0;
        end else if (e_mr || e_ar) begin
            c = e_mr ? bus.m_cmd : bus.a_cmd;
            d = e_mr ? bus.m_dur : bus.a_dur;
            job_src    = !e_mr;
            brake_left = 0;
            run_left   = 0;
            if (c > 3'd4) e_err = 1'b1;
            else if (d == '0) e_done = 1'b1;
            else begin
                job_cmd  = c;
                run_left = int'(d) * TICK;
                if (c != 3'd0 && last_dir != 3'd0 && c != last_dir) brake_left = DEADC;
                else last_dir = c;
            end
        end else if (brake_left > 0) begin
            brake_left--;
            if (brake_left == 0) last_dir = job_cmd;
        end else if (run_left > 0) begin
            run_left--;
            if (run_left == 0) e_done = 1'b1;
        end
        e_pins = (brake_left == 0 && run_left > 0) ? pmap[job_cmd] : 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic src, input logic [2:0] c, input logic [DW-1:0] d);
        if (src) begin bus.a_valid = 1'b1; bus.a_cmd = c; bus.a_dur = d; end
        else     begin bus.m_valid = 1'b1; bus.m_cmd = c; bus.m_dur = d; end
        for (int i = 0; i < 4000; i++) begin
            step();
            if (src ? e_ar : e_mr) begin
                if (src) bus.a_valid = 1'b0; else bus.m_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 32'(bus.m_valid | bus.a_valid), 32'(0));
        bus.m_valid = 1'b0;
        bus.a_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000; i++) begin
            if (brake_left == 0 && run_left == 0) return;
            step();
        end
        chk("idle_timeout", 32'(run_left + brake_left), 32'(0));
    endtask

    function automatic logic [2:0] rand_cmd();
        int r;
        r = int'($urandom_range(0, 9));
        return (r < 8) ? 3'(r % 5) : 3'($urandom_range(5, 7));
    endfunction

    function automatic logic [DW-1:0] rand_dur();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0)  return '0;
        if (r == 15) return DW'($urandom_range(20, 40));
        return DW'($urandom_range(1, 3));
    endfunction

    initial begin
        rst = 1'b1; estop = 1'b0;
        bus.m_valid = 1'b0; bus.m_cmd = 3'd0; bus.m_dur = '0;
        bus.a_valid = 1'b0; bus.a_cmd = 3'd0; bus.a_dur = '0;
        @(posedge clk); @(posedge clk); #1;
        steps(2);
        rst = 1'b0;
        steps(1);

        send(1'b0, 3'd1, 8'd2); wait_idle(); step();
        send(1'b0, 3'd1, 8'd1); wait_idle(); send(1'b0, 3'd2, 8'd1); wait_idle(); step();

        bus.a_valid = 1'b1; bus.a_cmd = 3'd4; bus.a_dur = 8'd1;
        send(1'b0, 3'd3, 8'd1);
        for (int i = 0; i < 200; i++) begin
            step();
            if (e_ar) break;
        end
        bus.a_valid = 1'b0;
        wait_idle(); step();

        send(1'b1, 3'd3, 8'd5); steps(6); send(1'b0, 3'd0, 8'd1); wait_idle(); step();

        send(1'b0, 3'd4, 8'd10); steps(15);
        estop = 1'b1; steps(2); estop = 1'b0;
        send(1'b0, 3'd4, 8'd10); wait_idle(); step();

        send(1'b1, 3'd6, 8'd3); steps(2); send(1'b1, 3'd1, 8'd0); steps(3);

        send(1'b0, 3'd1, 8'd255); wait_idle();
        send(1'b1, 3'd2, 8'd1); steps(2); send(1'b0, 3'd3, 8'd1); wait_idle(); step();

        send(1'b0, 3'd3, 8'd3); steps(5);
        rst = 1'b1; steps(2); rst = 1'b0; steps(3);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (bus.m_valid) begin
                if (e_mr || $urandom_range(0, 49) == 0) bus.m_valid = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                bus.m_valid = 1'b1; bus.m_cmd = rand_cmd(); bus.m_dur = rand_dur();
            end
            if (bus.a_valid) begin
                if (e_ar || $urandom_range(0, 49) == 0) bus.a_valid = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.a_valid = 1'b1; bus.a_cmd = rand_cmd(); bus.a_dur = rand_dur();
            end
            if (estop) estop = ($urandom_range(0, 1) == 0);
            else       estop = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
